// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  // Arbiter FSM states: idle, serving a data access, serving a fetch.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } arb_state_e;

  // Enable bit positions inside the read (4-bit) and write (3-bit) commands.
  localparam int RD_EN_BIT = 3;
  localparam int WR_EN_BIT = 2;

  // Read command issued for an instruction fetch: enable + funct3 = LW.
  localparam logic [3:0] WORD_READ = 4'b1010;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory port between the instruction-fetch and data
// ports of a CPU. Data accesses win over fetches; the CPU is stalled through
// BUSYWAIT until every request it holds has been served. A per-access wait
// counter turns a missing MEM_ACK into a sticky ERR and a zero-data completion.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            CLK,
  input  logic            RST,
  // CPU instruction port
  input  logic            I_REQ,
  input  logic [XLEN-1:0] I_ADDR,
  output logic [XLEN-1:0] I_DATA,
  // CPU data port
  input  logic [3:0]      D_READ,
  input  logic [2:0]      D_WRITE,
  input  logic [XLEN-1:0] D_ADDR,
  input  logic [XLEN-1:0] D_WDATA,
  output logic [XLEN-1:0] D_RDATA,
  output logic            BUSYWAIT,
  // Unified memory port
  output logic [3:0]      MEM_READ,
  output logic [2:0]      MEM_WRITE,
  output logic [XLEN-1:0] MEM_ADDR,
  output logic [XLEN-1:0] MEM_WDATA,
  input  logic [XLEN-1:0] MEM_RDATA,
  input  logic            MEM_ACK,
  output logic            ERR
);

  localparam int CW = $clog2(TIMEOUT + 1);
  // Counter value during the last cycle an access may still wait for MEM_ACK.
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  arb_state_e      state_q, state_d;
  logic [3:0]      mem_read_q, mem_read_d;
  logic [2:0]      mem_write_q, mem_write_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] i_data_q, i_data_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            err_q, err_d;
  logic            d_done_q, d_done_d;
  logic            i_done_q, i_done_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;

  logic d_pend;
  logic i_pend;
  logic busy;
  logic wait_expired;

  // Pending-request decode and the combinational stall back to the CPU.
  always_comb begin
    d_pend       = (D_READ[RD_EN_BIT] | D_WRITE[WR_EN_BIT]) & ~d_done_q;
    i_pend       = I_REQ & ~i_done_q;
    busy         = d_pend | i_pend;
    wait_expired = (wait_cnt_q == WAIT_LAST);
  end

  assign BUSYWAIT  = busy;
  assign MEM_READ  = mem_read_q;
  assign MEM_WRITE = mem_write_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign I_DATA    = i_data_q;
  assign D_RDATA   = d_rdata_q;
  assign ERR       = err_q;

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d     = state_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    i_data_d    = i_data_q;
    d_rdata_d   = d_rdata_q;
    err_d       = err_q;
    d_done_d    = d_done_q;
    i_done_d    = i_done_q;
    wait_cnt_d  = wait_cnt_q;

    unique case (state_q)
      IDLE: begin
        // MEM_ACK is deliberately not looked at here.
        if (d_pend) begin
          state_d     = DACC;
          mem_addr_d  = D_ADDR;
          mem_read_d  = D_READ;
          mem_write_d = D_WRITE;
          mem_wdata_d = D_WDATA;
          wait_cnt_d  = '0;
        end else if (i_pend) begin
          state_d     = IACC;
          mem_addr_d  = I_ADDR;
          mem_read_d  = WORD_READ;
          mem_write_d = '0;
          wait_cnt_d  = '0;
        end
      end

      DACC: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (MEM_ACK) begin
          // Stores complete without disturbing the last loaded value.
          if (mem_read_q[RD_EN_BIT]) d_rdata_d = MEM_RDATA;
          d_done_d    = 1'b1;
          mem_read_d  = '0;
          mem_write_d = '0;
          state_d     = IDLE;
        end else if (wait_expired) begin
          err_d       = 1'b1;
          d_rdata_d   = '0;
          d_done_d    = 1'b1;
          mem_read_d  = '0;
          mem_write_d = '0;
          state_d     = IDLE;
        end
      end

      IACC: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        if (MEM_ACK) begin
          i_data_d    = MEM_RDATA;
          i_done_d    = 1'b1;
          mem_read_d  = '0;
          mem_write_d = '0;
          state_d     = IDLE;
        end else if (wait_expired) begin
          err_d       = 1'b1;
          i_data_d    = '0;
          i_done_d    = 1'b1;
          mem_read_d  = '0;
          mem_write_d = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // The CPU advances on any edge without a stall, retiring both done marks.
    if (!busy) begin
      d_done_d = 1'b0;
      i_done_d = 1'b0;
    end
  end

  // State and registered-output flops; reset abandons any access in flight.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values computed above.
    if (RST) begin
      state_q     <= IDLE;
      mem_read_q  <= '0;
      mem_write_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
      d_done_q    <= 1'b0;
      i_done_q    <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      i_data_q    <= i_data_d;
      d_rdata_q   <= d_rdata_d;
      err_q       <= err_d;
      d_done_q    <= d_done_d;
      i_done_q    <= i_done_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single accesses plus hand-written
// sequences for priority, back-to-back fetches, reset mid-access and timeout.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        I_REQ;
  logic [31:0] I_ADDR;
  logic [31:0] I_DATA;
  logic [3:0]  D_READ;
  logic [2:0]  D_WRITE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic [31:0] D_RDATA;
  logic        BUSYWAIT;
  logic [3:0]  MEM_READ;
  logic [2:0]  MEM_WRITE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  logic        MEM_ACK;
  logic        ERR;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.XLEN(32), .TIMEOUT(8)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .I_REQ    (I_REQ),
    .I_ADDR   (I_ADDR),
    .I_DATA   (I_DATA),
    .D_READ   (D_READ),
    .D_WRITE  (D_WRITE),
    .D_ADDR   (D_ADDR),
    .D_WDATA  (D_WDATA),
    .D_RDATA  (D_RDATA),
    .BUSYWAIT (BUSYWAIT),
    .MEM_READ (MEM_READ),
    .MEM_WRITE(MEM_WRITE),
    .MEM_ADDR (MEM_ADDR),
    .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA),
    .MEM_ACK  (MEM_ACK),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  // One single-access transaction and its hand-computed results.
  typedef struct {
    logic        is_data;
    logic [3:0]  d_read;
    logic [2:0]  d_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_cycle;
    logic [31:0] rdata;
    logic [3:0]  exp_mrd;
    logic [2:0]  exp_mwr;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_i_data;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    I_REQ   = 1'b0;
    I_ADDR  = '0;
    D_READ  = '0;
    D_WRITE = '0;
    D_ADDR  = '0;
    D_WDATA = '0;
  endtask

  // Issue the request in cycle 0, ACK in cycle ack_cycle, check release in
  // cycle ack_cycle+1, then let the CPU advance for one cycle.
  task automatic run_vec(input vec_t v, input string tag);
    if (v.is_data) begin
      D_READ  = v.d_read;
      D_WRITE = v.d_write;
      D_ADDR  = v.addr;
      D_WDATA = v.wdata;
    end else begin
      I_REQ  = 1'b1;
      I_ADDR = v.addr;
    end
    #1;
    check({tag, "_busy_c0"}, 32'(BUSYWAIT), 32'd1);
    for (int c = 1; c <= v.ack_cycle; c++) begin
      tick();
      check($sformatf("%s_mrd_c%0d", tag, c), 32'(MEM_READ), 32'(v.exp_mrd));
      check($sformatf("%s_mwr_c%0d", tag, c), 32'(MEM_WRITE), 32'(v.exp_mwr));
      check($sformatf("%s_maddr_c%0d", tag, c), MEM_ADDR, v.addr);
      check($sformatf("%s_busy_c%0d", tag, c), 32'(BUSYWAIT), 32'd1);
      if (v.is_data && v.d_write[2])
        check($sformatf("%s_mwdata_c%0d", tag, c), MEM_WDATA, v.wdata);
      if (c == v.ack_cycle) begin
        MEM_ACK   = 1'b1;
        MEM_RDATA = v.rdata;
      end
    end
    tick();
    MEM_ACK   = 1'b0;
    MEM_RDATA = '0;
    check({tag, "_busy_done"}, 32'(BUSYWAIT), 32'd0);
    check({tag, "_mrd_done"}, 32'(MEM_READ), 32'd0);
    check({tag, "_mwr_done"}, 32'(MEM_WRITE), 32'd0);
    check({tag, "_d_rdata"}, D_RDATA, v.exp_d_rdata);
    check({tag, "_i_data"}, I_DATA, v.exp_i_data);
    clear_inputs();
    tick();
  endtask

  // Safety net: the bench must always end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t post;
    logic [31:0] b2b_addr[3];
    logic [31:0] b2b_data[3];

    //            is_d  d_read   d_write addr          wdata         ack rdata         mrd      mwr     d_rdata       i_data
    vecs[0] = '{1'b0, 4'b0000, 3'b000, 32'h0000_0100, 32'h0,        3, 32'h0050_0093, 4'b1010, 3'b000, 32'h0,        32'h0050_0093};
    vecs[1] = '{1'b1, 4'b1010, 3'b000, 32'h0000_2000, 32'h0,        1, 32'h1122_3344, 4'b1010, 3'b000, 32'h1122_3344, 32'h0050_0093};
    vecs[2] = '{1'b1, 4'b0000, 3'b110, 32'h0000_3000, 32'hDEAD_BEEF, 4, 32'hCAFE_F00D, 4'b0000, 3'b110, 32'h1122_3344, 32'h0050_0093};
    vecs[3] = '{1'b1, 4'b1000, 3'b000, 32'h0000_2001, 32'h0,        2, 32'h0000_00AB, 4'b1000, 3'b000, 32'h0000_00AB, 32'h0050_0093};
    vecs[4] = '{1'b0, 4'b0000, 3'b000, 32'h0000_0200, 32'h0,        1, 32'h0000_0013, 4'b1010, 3'b000, 32'h0000_00AB, 32'h0000_0013};

    b2b_addr = '{32'h0, 32'h4, 32'h8};
    b2b_data = '{32'h0000_0113, 32'h0010_0193, 32'h0020_0213};

    RST       = 1'b1;
    MEM_ACK   = 1'b0;
    MEM_RDATA = '0;
    clear_inputs();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Reset state
    check("rst_busy",   32'(BUSYWAIT),  32'd0);
    check("rst_mrd",    32'(MEM_READ),  32'd0);
    check("rst_mwr",    32'(MEM_WRITE), 32'd0);
    check("rst_maddr",  MEM_ADDR,       32'd0);
    check("rst_err",    32'(ERR),       32'd0);
    check("rst_i_data", I_DATA,         32'd0);

    // Table of single accesses
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Load and fetch together: data first, one IDLE cycle, then the fetch.
    D_READ = 4'b1010; D_ADDR = 32'h2000; I_REQ = 1'b1; I_ADDR = 32'h104;
    #1 check("both_busy_c0", 32'(BUSYWAIT), 32'd1);
    tick();
    check("both_maddr_c1", MEM_ADDR, 32'h2000);
    check("both_mrd_c1", 32'(MEM_READ), 32'(4'b1010));
    tick();
    MEM_ACK = 1'b1; MEM_RDATA = 32'h0000_0055;
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    check("both_busy_c3", 32'(BUSYWAIT), 32'd1);
    check("both_mrd_c3", 32'(MEM_READ), 32'd0);
    check("both_d_rdata", D_RDATA, 32'h0000_0055);
    tick();
    check("both_maddr_c4", MEM_ADDR, 32'h104);
    check("both_mrd_c4", 32'(MEM_READ), 32'(4'b1010));
    check("both_busy_c4", 32'(BUSYWAIT), 32'd1);
    MEM_ACK = 1'b1; MEM_RDATA = 32'h0000_0066;
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    check("both_busy_c5", 32'(BUSYWAIT), 32'd0);
    check("both_i_data", I_DATA, 32'h0000_0066);
    check("both_d_hold", D_RDATA, 32'h0000_0055);
    clear_inputs();
    tick();

    // Back-to-back fetches with a one-cycle ACK; I_REQ never drops.
    I_REQ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      I_ADDR = b2b_addr[i];
      #1 check($sformatf("b2b%0d_busy_c0", i), 32'(BUSYWAIT), 32'd1);
      tick();
      check($sformatf("b2b%0d_maddr", i), MEM_ADDR, b2b_addr[i]);
      MEM_ACK = 1'b1; MEM_RDATA = b2b_data[i];
      tick();
      MEM_ACK = 1'b0; MEM_RDATA = '0;
      check($sformatf("b2b%0d_busy_c2", i), 32'(BUSYWAIT), 32'd0);
      check($sformatf("b2b%0d_i_data", i), I_DATA, b2b_data[i]);
      tick();
    end
    clear_inputs();
    tick();

    // Reset in the middle of a data access, then a stray ACK.
    D_READ = 4'b1010; D_ADDR = 32'h5000;
    tick();
    check("rmid_mrd_c1", 32'(MEM_READ), 32'(4'b1010));
    check("rmid_maddr_c1", MEM_ADDR, 32'h5000);
    #2;
    RST = 1'b1;
    clear_inputs();
    #1;
    check("rmid_mrd",    32'(MEM_READ),  32'd0);
    check("rmid_mwr",    32'(MEM_WRITE), 32'd0);
    check("rmid_maddr",  MEM_ADDR,       32'd0);
    check("rmid_mwdata", MEM_WDATA,      32'd0);
    check("rmid_i_data", I_DATA,         32'd0);
    check("rmid_d_rdata", D_RDATA,       32'd0);
    check("rmid_err",    32'(ERR),       32'd0);
    check("rmid_busy",   32'(BUSYWAIT),  32'd0);
    @(negedge CLK);
    RST = 1'b0;
    tick();
    MEM_ACK = 1'b1; MEM_RDATA = 32'hFFFF_FFFF;
    tick();
    MEM_ACK = 1'b0; MEM_RDATA = '0;
    check("late_ack_d_rdata", D_RDATA, 32'd0);
    check("late_ack_i_data", I_DATA, 32'd0);
    check("late_ack_mrd", 32'(MEM_READ), 32'd0);
    check("late_ack_busy", 32'(BUSYWAIT), 32'd0);
    tick();
    post = '{1'b1, 4'b1010, 3'b000, 32'h6000, 32'h0, 2, 32'h0BAD_F00D, 4'b1010, 3'b000, 32'h0BAD_F00D, 32'h0};
    run_vec(post, "post_rst");

    // Timeout: no ACK for a load; ERR rises after 8 waiting cycles.
    D_READ = 4'b1010; D_ADDR = 32'h7000;
    #1 check("to_busy_c0", 32'(BUSYWAIT), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("to_err_c%0d", c), 32'(ERR), 32'd0);
      check($sformatf("to_busy_c%0d", c), 32'(BUSYWAIT), 32'd1);
    end
    tick();
    check("to_err_c9", 32'(ERR), 32'd1);
    check("to_busy_c9", 32'(BUSYWAIT), 32'd0);
    check("to_d_rdata", D_RDATA, 32'd0);
    check("to_mrd_c9", 32'(MEM_READ), 32'd0);
    clear_inputs();
    tick();
    check("to_err_sticky", 32'(ERR), 32'd1);
    post = '{1'b0, 4'b0000, 3'b000, 32'h300, 32'h0, 1, 32'h0000_0073, 4'b1010, 3'b000, 32'h0, 32'h0000_0073};
    run_vec(post, "after_to");
    check("err_still_set", 32'(ERR), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_arbiter
